imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream loader for the single-cycle RV32I core.
- Receives a byte stream from a UART receiver, assembles little-endian 32-bit words, and writes them into instruction memory starting at address 0.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-valid image has been loaded.
- Sits between the UART RX block and the instruction memory write port; cpu_hold is ORed into the CPU reset at top level.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; maximum accepted image size.
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes once a frame has started.
- ADDR_W, 32, width of imem_addr (byte address).

Ports:
- clk  in  1  system clock, all logic on rising edge
- arst  in  1  reset: synchronous, active-high
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- imem_we  out  1  instruction memory write enable, one-cycle pulse
- imem_addr  out  ADDR_W  byte address, word aligned (word_index*4)
- imem_wdata  out  32  word to write
- cpu_hold  out  1  1 = keep CPU in reset
- done  out  1  image loaded and verified
- err_code  out  2  00 none, 01 size, 10 checksum, 11 timeout
- words_loaded  out  $clog2(DEPTH_WORDS)+1  count of words written

Behaviour:
- Frame format:
  - 4-byte little-endian word count N.
  - N words, each 4 bytes little-endian.
  - 1 checksum byte equal to the XOR of all payload bytes; header bytes are excluded.
- Reset (arst=1 at a clock edge):
  - state=S_HDR; imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err_code=00, words_loaded=0.
  - Byte counter, checksum accumulator and timeout counter are cleared.
  - Reset mid-frame aborts the frame; memory already written is not erased.
- States:
  - S_HDR: collect 4 bytes into N. After the 4th byte:
    - N > DEPTH_WORDS → S_ERR, err_code=01.
    - N == 0 → S_CSUM.
    - otherwise → S_DATA.
  - S_DATA: assemble 4 bytes into a word and XOR each byte into csum.
    - On the cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_addr=words_loaded*4, imem_wdata=assembled word; words_loaded increments in that same cycle.
    - After the N-th word → S_CSUM.
  - S_CSUM: on the next byte:
    - equal to csum → S_DONE.
    - otherwise → S_ERR, err_code=10.
  - S_DONE: done=1 and cpu_hold=0, both registered and visible the cycle after the checksum byte. All further rx bytes are ignored. Exit only by reset.
  - S_ERR: cpu_hold=1, done=0, err_code holds its value. Bytes are ignored. Exit only by reset.
- Latency: a byte is accepted on a rising edge with rx_valid=1. There is no backpressure, so every strobe is consumed. The write pulse occurs exactly 1 cycle after the 4th byte of a word.
- Timeout:
  - The counter runs only in S_HDR after ≥1 header byte has arrived, and in S_DATA and S_CSUM.
  - It clears on every rx_valid.
  - When it reaches TIMEOUT_CYC → S_ERR, err_code=11.
  - rx_valid arriving in the same cycle as expiry wins: the byte is accepted and the counter clears.
- Widths:
  - N is compared as a full 32-bit unsigned value; there is no truncation before the size check.
  - imem_addr is zero-extended to ADDR_W.
- imem_we is never asserted outside S_DATA.

Decomposition:
- Package boot_pkg:
  - state enum {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR}
  - err codes ERR_NONE/ERR_SIZE/ERR_CSUM/ERR_TIMEOUT
  - HDR_BYTES=4, BYTES_PER_WORD=4
- Sub-module byte_assembler: 2-bit byte index plus 32-bit little-endian shift register with a word_ready strobe. It is reused for the header and the payload, and cleared on state entry and on reset.

Test Plan:
- Nominal load:
  - Stimulus: N=2, bytes 93 00 50 00 13 01 A0 00, csum 0x71.
  - Response: writes (addr 0, 0x00500093) and (addr 4, 0x00A00113), each a 1-cycle pulse. words_loaded=2; done=1 and cpu_hold=0 one cycle after the csum byte.
- Oversize image:
  - Stimulus: header N=65 with DEPTH_WORDS=64.
  - Response: err_code=01 after the 4th header byte; no imem_we ever; cpu_hold=1.
- Bad checksum:
  - Stimulus: nominal frame with csum 0x70.
  - Response: both writes occur, then err_code=10, done=0, cpu_hold=1; later bytes are ignored.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16; send 3 header bytes, then idle.
  - Response: err_code=11 exactly 16 cycles after the last byte.
  - Repeat with a byte arriving on cycle 16: no error.
- Empty image:
  - Stimulus: N=0, csum 0x00.
  - Response: done=1, words_loaded=0, no writes.
  - Subsequent bytes 0xFF ×8 cause no change.
- Reset mid-payload:
  - Stimulus: assert arst for 1 cycle after the first word is written.
  - Response: all outputs return to reset values.
  - A fresh nominal frame then loads correctly from addr 0.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The frame is: 4-byte LE word count, N LE words, one XOR checksum byte.
package boot_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SIZE    = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    // Byte address of a word index, zero-extended to 32 bits.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = the loader itself; slave = the UART/imem environment around it.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_assembler.sv
// Collects four bytes into a little-endian word; shared by header and payload.
// word_o/ready_o are combinational so the 4th byte can be acted on at its own edge.
module byte_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o,
    output logic        ready_o
);
    logic [1:0]  idx_q,   idx_d;
    logic [31:0] shreg_q, shreg_d;

    // New bytes enter at the top, so after four bytes the first one sits in [7:0].
    assign word_o  = {byte_i, shreg_q[31:8]};
    assign ready_o = valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign idx_o   = idx_q;

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clr_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (valid_i) begin
            idx_d   = idx_q + 2'd1;
            shreg_d = word_o;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// UART-fed boot loader: writes a checksummed image into imem from address 0
// and holds the CPU in reset until the whole image has been verified.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int ADDR_W      = 32,
    localparam int WL_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic                 clk,
    input  logic                 arst,
    imem_boot_loader_if.master   bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic [1:0]           err_code,
    output logic [WL_W-1:0]      words_loaded
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    err_e              err_q,   err_d;
    logic [31:0]       n_q,     n_d;
    logic [WL_W-1:0]   wl_q,    wl_d;
    logic [7:0]        csum_q,  csum_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q,  done_d;
    logic              hold_q,  hold_d;

    logic        asm_clr, asm_valid, asm_ready;
    logic [1:0]  asm_idx;
    logic [31:0] asm_word;
    logic        last_done, csum_hit, tmo_active;

    byte_assembler u_asm (
        .clk     (clk),
        .arst    (arst),
        .clr_i   (asm_clr),
        .valid_i (asm_valid),
        .byte_i  (bus.rx_data),
        .idx_o   (asm_idx),
        .word_o  (asm_word),
        .ready_o (asm_ready)
    );

    // Final write pulse is in flight; a byte arriving now is already the checksum.
    assign last_done  = we_q && (32'(wl_q) == n_q);
    assign csum_hit   = (bus.rx_data == csum_q);
    assign tmo_active = ((state_q == S_HDR) && (asm_idx != 2'd0)) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign asm_clr    = (state_d != state_q);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        n_d       = n_q;
        wl_d      = wl_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_valid = 1'b0;

        unique case (state_q)
            S_HDR: begin
                asm_valid = bus.rx_valid;
                csum_d    = '0;
                if (asm_ready) begin
                    n_d = asm_word;
                    if (asm_word > 32'(DEPTH_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = ERR_SIZE;
                    end else if (asm_word == 32'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_done) begin
                    if (bus.rx_valid) begin
                        state_d = csum_hit ? S_DONE : S_ERR;
                        err_d   = csum_hit ? err_q  : ERR_CSUM;
                    end else begin
                        state_d = S_CSUM;
                    end
                end else begin
                    asm_valid = bus.rx_valid;
                    if (bus.rx_valid) csum_d = csum_q ^ bus.rx_data;
                    if (asm_ready) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(word_byte_addr(32'(wl_q)));
                        wdata_d = asm_word;
                        wl_d    = wl_q + WL_W'(1);
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    state_d = csum_hit ? S_DONE : S_ERR;
                    err_d   = csum_hit ? err_q  : ERR_CSUM;
                end
            end
            S_DONE, S_ERR: ;
            default: state_d = S_ERR;
        endcase

        // A byte in the expiry cycle wins over the timeout.
        if (!tmo_active || bus.rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            tmo_d   = '0;
            state_d = S_ERR;
            err_d   = ERR_TIMEOUT;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        done_d = (state_d == S_DONE);
        hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= S_HDR;
            err_q   <= ERR_NONE;
            n_q     <= '0;
            wl_q    <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign err_code       = err_q;
    assign words_loaded   = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench for imem_boot_loader: expected imem writes are queued as
// frames are sent and popped by a monitor on every write pulse.
module tb_imem_boot_loader;
    localparam int DEPTH = 64;
    localparam int TMO   = 16;
    localparam int AW    = 32;
    localparam int WL_W  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            arst;
    logic            cpu_hold, done;
    logic [1:0]      err_code;
    logic [WL_W-1:0] words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(
        .DEPTH_WORDS (DEPTH),
        .TIMEOUT_CYC (TMO),
        .ADDR_W      (AW)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  exp_wr;
    int   cyc     = 0;
    int   last_rx = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) begin
        if (bus.rx_valid) last_rx <= cyc;
        cyc <= cyc + 1;
    end

    // Each write must be a single-cycle pulse one edge after the 4th byte.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            chk("we_latency", 64'(cyc - last_rx), 64'd1);
            chk("we_single", {63'd0, prev_we}, 64'd0);
            chk("we_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                exp_wr = exp_q.pop_front();
                chk("wr_addr", 64'(bus.imem_addr), 64'(exp_wr.addr));
                chk("wr_data", 64'(bus.imem_wdata), 64'(exp_wr.data));
            end
        end
        prev_we <= bus.imem_we;
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},    64'(bus.imem_we),    64'd0);
        chk({tag, "_addr"},  64'(bus.imem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
        chk({tag, "_hold"},  64'(cpu_hold),       64'd1);
        chk({tag, "_done"},  64'(done),           64'd0);
        chk({tag, "_err"},   64'(err_code),       64'd0);
        chk({tag, "_wl"},    64'(words_loaded),   64'd0);
    endtask

    task automatic nominal(input logic [7:0] cs);
        push_wr(32'd0, 32'h0050_0093);
        push_wr(32'd4, 32'h00A0_0113);
        send_word(32'd2, 1);
        send_word(32'h0050_0093, 1);
        send_word(32'h00A0_0113, 1);
        chk("pre_cs_done", 64'(done), 64'd0);
        chk("pre_cs_hold", 64'(cpu_hold), 64'd1);
        send(cs, 0);
    endtask

    logic [31:0] w;
    logic [7:0]  cs;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        arst         = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        chk_idle("rst");

        // No timeout while waiting for the first header byte.
        repeat (40) @(negedge clk);
        chk("pre_hdr_err", 64'(err_code), 64'd0);

        // Nominal load; trailing bytes are ignored.
        nominal(8'h71);
        chk("nom_done", 64'(done), 64'd1);
        chk("nom_hold", 64'(cpu_hold), 64'd0);
        chk("nom_err",  64'(err_code), 64'd0);
        chk("nom_wl",   64'(words_loaded), 64'd2);
        chk("nom_q",    64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 6; i++) send(8'hAA, 0);
        chk("nom_post_done", 64'(done), 64'd1);
        chk("nom_post_wl",   64'(words_loaded), 64'd2);

        // Oversize N=65: error right after the 4th header byte.
        do_reset();
        chk_idle("rst2");
        send_word(32'd65, 0);
        chk("size_err",  64'(err_code), 64'd1);
        chk("size_hold", 64'(cpu_hold), 64'd1);
        chk("size_done", 64'(done), 64'd0);
        send_word(32'h1234_5678, 0);
        repeat (20) @(negedge clk);
        chk("size_err_hold", 64'(err_code), 64'd1);
        chk("size_wl", 64'(words_loaded), 64'd0);

        // Size check uses all 32 bits (low byte alone would look like 64).
        do_reset();
        send_word(32'h0001_0040, 0);
        chk("size_wide_err", 64'(err_code), 64'd1);

        // Full-depth image, back-to-back bytes including the checksum.
        do_reset();
        cs = 8'h00;
        send_word(32'(DEPTH), 0);
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'h9E37_79B9 * (i + 1);
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            push_wr(32'(i * 4), w);
            send_word(w, 0);
        end
        send(cs, 0);
        chk("full_done", 64'(done), 64'd1);
        chk("full_wl",   64'(words_loaded), 64'(DEPTH));
        chk("full_q",    64'(exp_q.size()), 64'd0);

        // Bad checksum.
        do_reset();
        nominal(8'h70);
        chk("bcs_err",  64'(err_code), 64'd2);
        chk("bcs_done", 64'(done), 64'd0);
        chk("bcs_hold", 64'(cpu_hold), 64'd1);
        chk("bcs_wl",   64'(words_loaded), 64'd2);
        send(8'h71, 0);
        chk("bcs_err_hold", 64'(err_code), 64'd2);
        chk("bcs_done2", 64'(done), 64'd0);

        // Timeout 16 cycles after the 3rd header byte.
        do_reset();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            chk("tmo_early", 64'(err_code), 64'd0);
        end
        @(negedge clk);
        chk("tmo_err",  64'(err_code), 64'd3);
        chk("tmo_hold", 64'(cpu_hold), 64'd1);

        // A byte on the expiry cycle wins.
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        repeat (TMO - 2) @(negedge clk);
        send(8'h00, 0);
        chk("tmo_race_err", 64'(err_code), 64'd0);
        send(8'h00, 0);
        chk("tmo_race_done", 64'(done), 64'd1);

        // Empty image, then junk bytes.
        do_reset();
        send_word(32'd0, 0);
        send(8'h00, 0);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_wl",   64'(words_loaded), 64'd0);
        for (int i = 0; i < 8; i++) send(8'hFF, 0);
        chk("empty_post_done", 64'(done), 64'd1);
        chk("empty_post_hold", 64'(cpu_hold), 64'd0);
        chk("empty_post_err",  64'(err_code), 64'd0);
        chk("empty_post_wl",   64'(words_loaded), 64'd0);

        // Reset after the first word, then a fresh frame from address 0.
        do_reset();
        push_wr(32'd0, 32'h0050_0093);
        send_word(32'd2, 1);
        send_word(32'h0050_0093, 0);
        do_reset();
        chk_idle("midrst");
        nominal(8'h71);
        chk("reload_done", 64'(done), 64'd1);
        chk("reload_wl",   64'(words_loaded), 64'd2);

        repeat (4) @(negedge clk);
        chk("final_q", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
